// File: rtl/ps2_tx_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
// Also holds the byte-level command encodings used by callers.
package ps2_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SHIFT,
    RELEASE
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line.
// A third flop keeps the previous synced level for fall detection.
module ps2_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic line_i,
  output logic sync_o,
  output logic fall_o
);

  logic [2:0] sh_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sh_q <= 3'b111;
    end else begin
      sh_q <= {sh_q[1:0], line_i};
    end
  end

  assign sync_o = sh_q[1];
  assign fall_o = sh_q[2] & ~sh_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter.
// Request-to-send, 11 device-clocked bits, ACK sample, line release.
module ps2_host_tx
  import ps2_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int CNT_W          = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output logic       tx_active,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam logic [CNT_W-1:0] INH_LAST =
    CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       byte_q, byte_d;
  logic             par_q, par_d;
  logic             nak_q, nak_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             done_q, done_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic clk_sync, clk_fall;
  logic dat_sync, dat_fall_unused;

  ps2_line_sync u_clk_sync (
    .clock  (clock),
    .reset  (reset),
    .line_i (ps2_clock_in),
    .sync_o (clk_sync),
    .fall_o (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clock  (clock),
    .reset  (reset),
    .line_i (ps2_data_in),
    .sync_o (dat_sync),
    .fall_o (dat_fall_unused)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      par_q    <= 1'b0;
      nak_q    <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      par_q    <= par_d;
      nak_q    <= nak_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    bit_d    = bit_q;
    byte_d   = byte_q;
    par_d    = par_q;
    nak_d    = nak_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    ack_d    = ack_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        cnt_d    = '0;
        if (cmd_valid) begin
          state_d  = INHIBIT;
          byte_d   = cmd_data;
          par_d    = odd_parity(cmd_data);
          bit_d    = '0;
          clk_oe_d = 1'b1;
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d  = START;
          cnt_d    = '0;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
        end
      end
      START: begin
        if (clk_fall) begin
          state_d  = SHIFT;
          cnt_d    = '0;
          bit_d    = 4'd1;
          dat_oe_d = ~byte_q[0];
        end else if (cnt_q == TO_LAST) begin
          state_d  = IDLE;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          done_d   = 1'b1;
          ack_d    = 1'b0;
          err_d    = 1'b1;
        end
      end
      SHIFT: begin
        if (clk_fall) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
          // bit_q is the count of edges already handled
          unique case (1'b1)
            (bit_q < 4'd8): dat_oe_d = ~byte_q[bit_q[2:0]];
            (bit_q == 4'd8): dat_oe_d = ~par_q;
            (bit_q == 4'd9): dat_oe_d = 1'b0;
            default: begin
              nak_d    = dat_sync;
              state_d  = RELEASE;
              bit_d    = '0;
              clk_oe_d = 1'b0;
              dat_oe_d = 1'b0;
            end
          endcase
        end else if (cnt_q == TO_LAST) begin
          state_d  = IDLE;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          done_d   = 1'b1;
          ack_d    = 1'b0;
          err_d    = 1'b1;
        end
      end
      RELEASE: begin
        if (clk_sync && dat_sync) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ack_d   = ~nak_q;
          err_d   = nak_q;
        end else if (cnt_q == TO_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ack_d   = 1'b0;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
      end
    endcase
  end

  assign cmd_ready    = (state_q == IDLE);
  assign tx_active    = (state_q != IDLE);
  assign ps2_clock_oe = clk_oe_q;
  assign ps2_data_oe  = dat_oe_q;
  assign done         = done_q;
  assign ack_ok       = ack_q;
  assign error        = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on open-drain lines,
// scoreboard queues for received frames and done responses.
module tb_ps2_host_tx;

  localparam int HALF = 40;

  logic       clock;
  logic       reset;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       ps2_clock_oe;
  logic       ps2_data_oe;
  logic       tx_active;
  logic       done;
  logic       ack_ok;
  logic       error;
  logic       dev_clk_low;
  logic       dev_dat_low;
  logic       clk_line;
  logic       dat_line;

  int n_tests = 0;
  int n_fail  = 0;
  int dev_edges = 0;

  logic [7:0] exp_frame[$];
  logic [1:0] exp_rsp[$];
  logic [1:0] mon_rsp;

  assign clk_line = ~(ps2_clock_oe | dev_clk_low);
  assign dat_line = ~(ps2_data_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (10),
    .TIMEOUT_CYCLES (200),
    .CNT_W          (20)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_data     (cmd_data),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .ps2_clock_in (clk_line),
    .ps2_data_in  (dat_line),
    .ps2_clock_oe (ps2_clock_oe),
    .ps2_data_oe  (ps2_data_oe),
    .tx_active    (tx_active),
    .done         (done),
    .ack_ok       (ack_ok),
    .error        (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && done) begin
      if (exp_rsp.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        mon_rsp = exp_rsp.pop_front();
        check("ack_ok", ack_ok, mon_rsp[1]);
        check("error", error, mon_rsp[0]);
      end
    end
  end

  task automatic device(input int n_edges, input bit ack);
    logic [9:0] fr;
    logic [7:0] e;
    bit ok;
    ok = 0;
    fr = '0;
    dev_edges = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (clk_line && !dat_line && !ps2_clock_oe) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("dev_start_seen", 0, 1);
      return;
    end
    repeat (HALF / 2) @(negedge clock);
    for (int k = 1; k <= n_edges; k++) begin
      dev_clk_low = 1'b1;
      dev_edges = k;
      repeat (HALF) @(negedge clock);
      dev_clk_low = 1'b0;
      if (k <= 10) fr[k-1] = dat_line;
      repeat (HALF / 2) @(negedge clock);
      if (k == 11) begin
        dev_dat_low = 1'b0;
      end else begin
        if (k == 10 && ack) dev_dat_low = 1'b1;
        repeat (HALF / 2) @(negedge clock);
      end
    end
    if (n_edges >= 10) begin
      if (exp_frame.size() == 0) begin
        check("spurious_frame", 1, 0);
      end else begin
        e = exp_frame.pop_front();
        check("dev_byte", fr[7:0], e);
        check("dev_parity", fr[8], ($countones(e) % 2) == 0);
        check("dev_stop", fr[9], 1);
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input bit frame,
                      input bit rsp, input bit ack, input bit err);
    @(negedge clock);
    check("accept_ready", cmd_ready, 1);
    cmd_data = b;
    cmd_valid = 1'b1;
    if (frame) exp_frame.push_back(b);
    if (rsp) exp_rsp.push_back({ack, err});
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic wait_edges(input int n, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (dev_edges >= n) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("edge_wait", dev_edges, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = '0;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_clock_oe", ps2_clock_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_tx_active", tx_active, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", {ack_ok, error}, 0);
    check("rst_ready", cmd_ready, 1);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // 1: set-LEDs with ACK, inhibit length
    fork device(11, 1); join_none
    send(8'hED, 1, 1, 1, 0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!ps2_clock_oe) break;
      n++;
    end
    check("inhibit_len", n, 10);
    check("start_data_oe", ps2_data_oe, 1);
    wait_done(3000);
    @(negedge clock);
    check("ready_after_done", cmd_ready, 1);
    check("idle_after_done", tx_active, 0);
    repeat (5) @(negedge clock);

    // 2: parity 0 and parity 1 bytes
    fork device(11, 1); join_none
    send(8'h01, 1, 1, 1, 0);
    wait_done(3000);
    repeat (5) @(negedge clock);
    fork device(11, 1); join_none
    send(8'hFF, 1, 1, 1, 0);
    wait_done(3000);
    repeat (5) @(negedge clock);

    // 3: NACK
    fork device(11, 0); join_none
    send(8'hA5, 1, 1, 0, 1);
    wait_done(3000);
    check("nak_clock_oe", ps2_clock_oe, 0);
    repeat (5) @(negedge clock);

    // 4a: device never clocks
    send(8'hF4, 0, 1, 0, 1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (ps2_data_oe) break;
    end
    check("start_reached", ps2_data_oe, 1);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      n++;
      if (done) break;
    end
    check("timeout_cycles", n, 200);
    check("to_oe", {ps2_clock_oe, ps2_data_oe}, 0);
    repeat (5) @(negedge clock);

    // 4b: stall after edge 5
    fork device(5, 1); join_none
    send(8'hED, 0, 1, 0, 1);
    wait_done(3000);
    check("stall_oe", {ps2_clock_oe, ps2_data_oe}, 0);
    repeat (60) @(negedge clock);

    // 5: reset mid-transfer after edge 4
    fork device(4, 1); join_none
    send(8'hFF, 0, 0, 0, 0);
    wait_edges(4, 2000);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_oe", {ps2_clock_oe, ps2_data_oe}, 0);
    check("mid_rst_active", tx_active, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_done", done, 0);
    reset = 1'b0;
    repeat (500) @(negedge clock);

    // 6a: cmd_valid while busy is ignored
    fork device(11, 1); join_none
    send(8'hED, 1, 1, 1, 0);
    wait_edges(3, 2000);
    @(negedge clock);
    cmd_data = 8'h55;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    wait_done(3000);
    repeat (400) @(negedge clock);

    // 6b: back-to-back commands
    fork
      begin
        device(11, 1);
        device(11, 1);
      end
    join_none
    send(8'hF4, 1, 1, 1, 0);
    @(negedge clock);
    cmd_data = 8'h3C;
    cmd_valid = 1'b1;
    exp_frame.push_back(8'h3C);
    exp_rsp.push_back(2'b10);
    wait_done(3000);
    check("b2b_ready", cmd_ready, 1);
    @(negedge clock);
    check("b2b_accept", tx_active, 1);
    check("b2b_inhibit", ps2_clock_oe, 1);
    cmd_valid = 1'b0;
    wait_done(3000);
    repeat (50) @(negedge clock);

    check("frames_left", exp_frame.size(), 0);
    check("rsp_left", exp_rsp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
